fpu_mac_avalon_master: RTL and testbench
========================================

FPU_MAC_AVALON_MASTER -- requirements
Module: fpu_mac_avalon_master

Interface
REQ-001 Parameters SHALL be: DRAIN_CYCLES, default 16, idle cycles after the last operand write before the result read; ADDR_A, default 3'h0, slave address for operand A; ADDR_B, default 3'h1, slave address for operand B; ADDR_CLR, default 3'h2, slave soft-reset address.
REQ-002 Ports SHALL be, in order:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- op_a  in  32  IEEE-754 single operand A.
- op_b  in  32  IEEE-754 single operand B.
- op_last  in  1  marks the final pair of an accumulation.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  block accepts pair.
- clear_req  in  1  one-cycle pulse: soft-reset the slave accumulator.
- result  out  32  accumulated result.
- result_valid  out  1  result held valid.
- result_ready  in  1  consumer accepts result.
- avm_address  out  3  Avalon-MM address.
- avm_writedata  out  32  Avalon-MM write data.
- avm_write  out  1  write request.
- avm_read  out  1  read request.
- avm_readdata  in  32  read data, valid in the cycle avm_read=1 and avm_waitrequest=0.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 A pair SHALL be accepted on a cycle with op_valid=1 and op_ready=1; {op_a, op_b, op_last} are stored in the operand buffer.
REQ-004 The FSM SHALL have the states IDLE, WR_A, WR_B, DRAIN, RD, OUT, and CLR.
REQ-005 IDLE SHALL go to CLR if clear_req is set, else to WR_A if the buffer is non-empty, else stay in IDLE.
REQ-006 WR_A SHALL drive avm_write=1, avm_address=ADDR_A, avm_writedata=A, holding all three stable while avm_waitrequest=1, and SHALL go to WR_B on the first cycle with avm_waitrequest=0.
REQ-007 WR_B SHALL behave as WR_A with ADDR_B and B, and on completion SHALL pop the buffer entry.
- If that entry's last flag is 1, the FSM SHALL go to DRAIN.
- Else it SHALL go to WR_A if the buffer is non-empty, else to IDLE.
REQ-008 DRAIN SHALL load a counter with DRAIN_CYCLES-1, decrement it each cycle, and go to RD when it reaches 0, giving exactly DRAIN_CYCLES cycles in DRAIN.
REQ-009 RD SHALL drive avm_read=1 and avm_address=ADDR_A.
- It SHALL capture avm_readdata into result on the first cycle with avm_waitrequest=0, then go to OUT.
- It SHALL ignore readdata while avm_waitrequest=1.
REQ-010 OUT SHALL assert result_valid with result held stable, and SHALL go to IDLE on the cycle result_ready=1.
REQ-011 CLR SHALL drive avm_write=1, avm_address=ADDR_CLR, avm_writedata=32'h0 until avm_waitrequest=0, then go to IDLE.
REQ-012 avm_write and avm_read SHALL never both be 1, and both SHALL be 0 in IDLE, DRAIN, and OUT.
REQ-013 clear_req SHALL be latched into a pending flag and serviced only from IDLE, never mid-pair; pulses that arrive while the flag is set SHALL merge into it.
REQ-014 Operand acceptance SHALL continue in all states while the buffer is not full; pairs arriving during DRAIN, RD, or OUT belong to the next accumulation.
REQ-015 Simultaneous push and pop on the same cycle SHALL leave the occupancy unchanged; a push into a full buffer SHALL be impossible because op_ready=0.
REQ-016 Buffer pointers SHALL wrap modulo depth.
REQ-017 Latency SHALL be as follows, for a single pair with op_last=1, accepted at cycle 0, buffer empty, and zero waitrequest:
- WR_A at cycle 2, WR_B at cycle 3;
- DRAIN at cycles 4..3+DRAIN_CYCLES;
- RD at cycle 4+DRAIN_CYCLES;
- result_valid from cycle 5+DRAIN_CYCLES.

Reset
REQ-018 With reset=1 at a clock edge, the FSM SHALL enter IDLE, the buffer SHALL empty, and the pending clear flag and drain counter SHALL clear.
REQ-019 Output reset values SHALL be:
- avm_write=0, avm_read=0, avm_address=0, avm_writedata=0;
- result=0, result_valid=0, busy=0;
- op_ready=1 from the first cycle after reset deasserts.
REQ-020 Reset mid-transfer SHALL abandon the transaction without a retry; pairs in flight are discarded.

Configuration
REQ-021 With FPU_MAC_MASTER_OPFIFO_EN defined, the operand buffer SHALL be a 4-entry FIFO.
REQ-022 Without FPU_MAC_MASTER_OPFIFO_EN, the operand buffer SHALL be a single register with op_ready = buffer empty; all other behaviour is identical.

Verification
REQ-023 The bench SHALL cover these scenarios, against an Avalon slave model whose result is the sum of products:
- Pair (0x40000000, 0x40400000), op_last=1, zero wait -> writes 0x40000000@0 then 0x40400000@1; read @0 at cycle 20 (DRAIN_CYCLES=16); result=0x40C00000, result_valid=1.
- Pairs (1.0,2.0), (3.0,1.0) with last on the second -> four writes in order; result=0x40A00000.
- avm_waitrequest=1 for 3 cycles during WR_A and 2 during RD -> address/data stable throughout; exactly one write and one read complete; same result.
- clear_req pulsed during WR_B -> pair completes, then one write @2 of 0x0; the next accumulation of (1.0,1.0) returns 0x3F800000.
- With the macro defined, 5 pairs pushed back-to-back while avm_waitrequest=1 -> op_ready=0 after 4 accepted; no pair lost or reordered.
- reset asserted in DRAIN -> next cycle avm_read=0, result_valid=0, busy=0, op_ready=1.

Source files
------------

// File: rtl/fpu_mac_avalon_master.sv
// Avalon-MM master that streams IEEE-754 operand pairs into a MAC slave and reads back the sum.
// Define FPU_MAC_MASTER_OPFIFO_EN for a 4-entry operand FIFO; otherwise a single-entry buffer is used.
module fpu_mac_avalon_master #(
  parameter int unsigned DRAIN_CYCLES = 16,
  parameter logic [2:0]  ADDR_A       = 3'h0,
  parameter logic [2:0]  ADDR_B       = 3'h1,
  parameter logic [2:0]  ADDR_CLR     = 3'h2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        op_last,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        clear_req,
  output logic [31:0] result,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [2:0]  avm_address,
  output logic [31:0] avm_writedata,
  output logic        avm_write,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR_A  = 3'd1,
    S_WR_B  = 3'd2,
    S_DRAIN = 3'd3,
    S_RD    = 3'd4,
    S_OUT   = 3'd5,
    S_CLR   = 3'd6
  } state_e;

  localparam int unsigned      CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             clr_pend_q, clr_pend_d;
  logic [31:0]      result_q, result_d;

  logic        push_s, pop_s;
  logic        buf_empty_s, buf_full_s, buf_multi_s;
  logic [64:0] head_s;
  logic        head_last_s;
  logic [31:0] head_a_s, head_b_s;

  assign op_ready    = ~buf_full_s;
  assign push_s      = op_valid & ~buf_full_s;
  assign head_last_s = head_s[64];
  assign head_a_s    = head_s[63:32];
  assign head_b_s    = head_s[31:0];

`ifdef FPU_MAC_MASTER_OPFIFO_EN
  logic [64:0] fifo_q [4];
  logic [64:0] fifo_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;

  // FIFO next state; 2-bit pointers wrap modulo the depth on their own.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      fifo_d[i] = fifo_q[i];
    end
    if (push_s) begin
      fifo_d[wr_ptr_q] = {op_last, op_a, op_b};
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= 65'd0;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_s      = fifo_q[rd_ptr_q];
  assign buf_empty_s = (count_q == 3'd0);
  assign buf_full_s  = (count_q == 3'd4);
  assign buf_multi_s = (count_q > 3'd1);
`else
  logic [64:0] slot_q, slot_d;
  logic        full_q, full_d;

  // Single-slot buffer: a push only lands when empty, a pop only when full.
  always_comb begin
    slot_d = slot_q;
    if (push_s) begin
      slot_d = {op_last, op_a, op_b};
      full_d = 1'b1;
    end else if (pop_s) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // Single-slot storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= 65'd0;
      full_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      full_q <= full_d;
    end
  end

  assign head_s      = slot_q;
  assign buf_empty_s = ~full_q;
  assign buf_full_s  = full_q;
  assign buf_multi_s = 1'b0;
`endif

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
      clr_pend_q  <= 1'b0;
      result_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      clr_pend_q  <= clr_pend_d;
      result_q    <= result_d;
    end
  end

  // Next-state logic; a pending clear is only taken from IDLE so a pair is never split.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    clr_pend_d  = clr_pend_q | clear_req;
    result_d    = result_q;
    pop_s       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_pend_q) begin
          state_d    = S_CLR;
          clr_pend_d = 1'b0;
        end else if (!buf_empty_s) begin
          state_d = S_WR_A;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_A: begin
        if (!avm_waitrequest) begin
          state_d = S_WR_B;
        end else begin
          state_d = S_WR_A;
        end
      end
      S_WR_B: begin
        if (!avm_waitrequest) begin
          pop_s = 1'b1;
          if (head_last_s) begin
            state_d     = S_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end else if (buf_multi_s) begin
            state_d = S_WR_A;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_WR_B;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = S_RD;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      S_RD: begin
        if (!avm_waitrequest) begin
          result_d = avm_readdata;
          state_d  = S_OUT;
        end else begin
          state_d = S_RD;
        end
      end
      S_OUT: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      S_CLR: begin
        if (!avm_waitrequest) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CLR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus and status outputs decoded from the state register.
  always_comb begin
    avm_write     = 1'b0;
    avm_read      = 1'b0;
    avm_address   = 3'h0;
    avm_writedata = 32'h0;
    case (state_q)
      S_WR_A: begin
        avm_write     = 1'b1;
        avm_address   = ADDR_A;
        avm_writedata = head_a_s;
      end
      S_WR_B: begin
        avm_write     = 1'b1;
        avm_address   = ADDR_B;
        avm_writedata = head_b_s;
      end
      S_RD: begin
        avm_read    = 1'b1;
        avm_address = ADDR_A;
      end
      S_CLR: begin
        avm_write   = 1'b1;
        avm_address = ADDR_CLR;
      end
      default: begin
        avm_write = 1'b0;
        avm_read  = 1'b0;
      end
    endcase
  end

  assign result       = result_q;
  assign result_valid = (state_q == S_OUT);
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpu_mac_avalon_master.sv
// Directed bench for fpu_mac_avalon_master with a sum-of-products Avalon slave model.
// Honours FPU_MAC_MASTER_OPFIFO_EN for the back-pressure depth check.
module tb_fpu_mac_avalon_master;

`ifdef FPU_MAC_MASTER_OPFIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  localparam logic [31:0] F1 = 32'h3F800000;
  localparam logic [31:0] F2 = 32'h40000000;
  localparam logic [31:0] F3 = 32'h40400000;
  localparam logic [31:0] F4 = 32'h40800000;
  localparam logic [31:0] F5 = 32'h40A00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] op_a = 32'h0, op_b = 32'h0;
  logic        op_last = 1'b0, op_valid = 1'b0, op_ready;
  logic        clear_req = 1'b0;
  logic [31:0] result;
  logic        result_valid, result_ready = 1'b0;
  logic [2:0]  avm_address;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_write, avm_read, avm_waitrequest;
  logic        busy;

  int n_chk = 0, n_fail = 0, cyc = 0, rw_viol = 0;

  // Slave model state
  real         acc = 0.0;
  logic [31:0] acc_bits = 32'h0, a_reg = 32'h0;
  logic [2:0]  wr_addr [256];
  logic [31:0] wr_data [256];
  int          wr_cyc [256];
  int          wr_n = 0, rd_n = 0, rd_cyc = 0;
  logic        hold_wait = 1'b0;
  int          wa_set = 0, wa_used = 0, rd_set = 0, rd_used = 0;
  logic        wa_stall, rd_stall;

  fpu_mac_avalon_master dut (
    .clk(clk), .reset(reset), .op_a(op_a), .op_b(op_b), .op_last(op_last),
    .op_valid(op_valid), .op_ready(op_ready), .clear_req(clear_req),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .avm_address(avm_address), .avm_writedata(avm_writedata), .avm_write(avm_write),
    .avm_read(avm_read), .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    m = m * (2.0 ** e);
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real         a;
    int          e;
    logic [31:0] m;
    logic        s;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = 32'($rtoi((a - 1.0) * 8388608.0 + 0.5));
    return {s, 8'(e + 127), m[22:0]};
  endfunction

  assign wa_stall = avm_write && (avm_address == 3'h0) && (wa_used != wa_set);
  assign rd_stall = avm_read && (rd_used != rd_set);
  assign avm_waitrequest = hold_wait | wa_stall | rd_stall;
  assign avm_readdata = (avm_read && !avm_waitrequest) ? acc_bits : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (wa_stall) wa_used <= wa_used + 1;
    if (rd_stall) rd_used <= rd_used + 1;
    if (avm_write && !avm_waitrequest) begin
      wr_addr[wr_n[7:0]] <= avm_address;
      wr_data[wr_n[7:0]] <= avm_writedata;
      wr_cyc[wr_n[7:0]]  <= cyc;
      wr_n <= wr_n + 1;
      case (avm_address)
        3'h0: a_reg <= avm_writedata;
        3'h1: begin
          acc      <= acc + f2r(a_reg) * f2r(avm_writedata);
          acc_bits <= r2f(acc + f2r(a_reg) * f2r(avm_writedata));
        end
        3'h2: begin
          acc      <= 0.0;
          acc_bits <= 32'h0;
        end
        default: a_reg <= a_reg;
      endcase
    end
    if (avm_read && !avm_waitrequest) begin
      rd_n   <= rd_n + 1;
      rd_cyc <= cyc;
    end
  end

  always @(negedge clk) if (avm_write && avm_read) rw_viol <= rw_viol + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offers one pair at a negedge, waits for acceptance, returns at the next negedge.
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic last,
                      input string tag, output int acc_c);
    int t = 0;
    op_a = a; op_b = b; op_last = last; op_valid = 1'b1;
    while (op_ready !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    check({tag, "_accept"}, 32'(op_ready), 32'd1);
    acc_c = cyc;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_result(input logic [31:0] exp, input string tag);
    int t = 0;
    while (result_valid !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    check({tag, "_valid"}, 32'(result_valid), 32'd1);
    check(tag, result, exp);
    @(negedge clk);
    check({tag, "_held"}, result, exp);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic do_clear(input string tag);
    int w = wr_n;
    int t = 0;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    while ((wr_n <= w || busy) && t < 300) begin @(negedge clk); t++; end
    check({tag, "_clr_addr"}, 32'(wr_addr[w[7:0]]), 32'd2);
  endtask

  initial begin
    int ac, w0, r0, idx, t;
    logic rdy;
    logic [31:0] bv [5];
    bv[0] = F1; bv[1] = F2; bv[2] = F3; bv[3] = F4; bv[4] = F5;

    repeat (3) @(negedge clk);
    check("rst_write", 32'(avm_write), 32'd0);
    check("rst_read", 32'(avm_read), 32'd0);
    check("rst_addr", 32'(avm_address), 32'd0);
    check("rst_wdata", avm_writedata, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_rvalid", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_op_ready", 32'(op_ready), 32'd1);

    // Single pair 2.0*3.0 with latency checks
    w0 = wr_n;
    push(F2, F3, 1'b1, "s1", ac);
    while (cyc < ac + 19) @(negedge clk);
    check("s1_drain_busy", 32'(busy), 32'd1);
    check("s1_drain_noread", 32'(avm_read), 32'd0);
    @(negedge clk);
    check("s1_rd_cycle", 32'(avm_read), 32'd1);
    check("s1_rd_addr", 32'(avm_address), 32'd0);
    check("s1_rv_early", 32'(result_valid), 32'd0);
    @(negedge clk);
    check("s1_rv_cycle", 32'(result_valid), 32'd1);
    check("s1_wa_addr", 32'(wr_addr[w0[7:0]]), 32'd0);
    check("s1_wa_data", wr_data[w0[7:0]], F2);
    check("s1_wa_cyc", 32'(wr_cyc[w0[7:0]]), 32'(ac + 2));
    check("s1_wb_addr", 32'(wr_addr[w0[7:0] + 8'd1]), 32'd1);
    check("s1_wb_data", wr_data[w0[7:0] + 8'd1], F3);
    check("s1_wb_cyc", 32'(wr_cyc[w0[7:0] + 8'd1]), 32'(ac + 3));
    check("s1_rd_at", 32'(rd_cyc), 32'(ac + 20));
    wait_result(32'h40C00000, "s1_res");

    // Clear pulsed during WR_B: 6+1 read first, then clear, then 1*1
    w0 = wr_n;
    op_a = F1; op_b = F1; op_last = 1'b1;
    push(F1, F1, 1'b1, "s4a", ac);
    t = 0;
    while (!(avm_write && avm_address == 3'h1) && t < 100) begin @(negedge clk); t++; end
    check("s4_wrb_seen", 32'(avm_write), 32'd1);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    wait_result(32'h40E00000, "s4_res_pre");
    push(F1, F1, 1'b1, "s4b", ac);
    wait_result(F1, "s4_res_post");
    check("s4_clr_addr", 32'(wr_addr[w0[7:0] + 8'd2]), 32'd2);
    check("s4_clr_data", wr_data[w0[7:0] + 8'd2], 32'h0);
    check("s4_clr_after_rd", 32'(wr_cyc[w0[7:0] + 8'd2] > wr_cyc[w0[7:0] + 8'd1] + 16), 32'd1);
    check("s4_wr_count", 32'(wr_n - w0), 32'd5);

    // Two pairs (1*2)+(3*1)
    do_clear("s2");
    w0 = wr_n;
    push(F1, F2, 1'b0, "s2a", ac);
    push(F3, F1, 1'b1, "s2b", ac);
    wait_result(F5, "s2_res");
    check("s2_w0", {wr_addr[w0[7:0]], wr_data[w0[7:0]][28:0]}, {3'd0, F1[28:0]});
    check("s2_w1", {wr_addr[w0[7:0] + 8'd1], wr_data[w0[7:0] + 8'd1][28:0]}, {3'd1, F2[28:0]});
    check("s2_w2", {wr_addr[w0[7:0] + 8'd2], wr_data[w0[7:0] + 8'd2][28:0]}, {3'd0, F3[28:0]});
    check("s2_w3", {wr_addr[w0[7:0] + 8'd3], wr_data[w0[7:0] + 8'd3][28:0]}, {3'd1, F1[28:0]});

    // Waitrequest stalls: 3 in WR_A, 2 in RD
    do_clear("s3");
    w0 = wr_n; r0 = rd_n;
    wa_set = wa_used + 3;
    rd_set = rd_used + 2;
    push(F2, F3, 1'b1, "s3", ac);
    t = 0;
    while (!avm_write && t < 50) begin @(negedge clk); t++; end
    for (int i = 0; i < 4; i++) begin
      check("s3_wa_hold", {29'd0, avm_write, avm_address[1:0]}, 32'd4);
      check("s3_wa_data", avm_writedata, F2);
      @(negedge clk);
    end
    t = 0;
    while (!avm_read && t < 50) begin @(negedge clk); t++; end
    for (int i = 0; i < 3; i++) begin
      check("s3_rd_hold", {29'd0, avm_read, avm_address[1:0]}, 32'd4);
      check("s3_rd_norv", 32'(result_valid), 32'd0);
      @(negedge clk);
    end
    wait_result(32'h40C00000, "s3_res");
    check("s3_wr_count", 32'(wr_n - w0), 32'd2);
    check("s3_rd_count", 32'(rd_n - r0), 32'd1);

    // Back-to-back pushes while the slave stalls
    do_clear("s5");
    w0 = wr_n;
    hold_wait = 1'b1;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      op_a = F1; op_b = bv[idx]; op_last = (idx == 4); op_valid = 1'b1;
      rdy = op_ready;
      @(negedge clk);
      if (rdy) idx++;
    end
    check("s5_accepted", 32'(idx), 32'(DEPTH));
    check("s5_op_ready_low", 32'(op_ready), 32'd0);
    hold_wait = 1'b0;
    while (idx < 5) begin
      push(F1, bv[idx], (idx == 4), "s5", ac);
      idx++;
    end
    wait_result(32'h41700000, "s5_res");
    for (int i = 0; i < 5; i++) begin
      check("s5_order_a", {wr_addr[w0[7:0] + 8'(2 * i)], wr_data[w0[7:0] + 8'(2 * i)][28:0]},
            {3'd0, F1[28:0]});
      check("s5_order_b", wr_data[w0[7:0] + 8'(2 * i + 1)], bv[i]);
    end

    // Reset in DRAIN abandons the accumulation
    push(F2, F3, 1'b1, "s6", ac);
    while (cyc < ac + 8) @(negedge clk);
    check("s6_in_drain", {30'd0, busy, avm_write | avm_read}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check("s6_read", 32'(avm_read), 32'd0);
    check("s6_rvalid", 32'(result_valid), 32'd0);
    check("s6_busy", 32'(busy), 32'd0);
    check("s6_op_ready", 32'(op_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("s6_op_ready_post", 32'(op_ready), 32'd1);
    r0 = rd_n;
    repeat (30) @(negedge clk);
    check("s6_no_read", 32'(rd_n - r0), 32'd0);
    check("s6_idle", 32'(busy), 32'd0);
    check("rw_exclusive", 32'(rw_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
